// File: rtl/acc_add4_pkg.sv
// Shared definitions for the streaming accumulating adder: state encoding
// and default widths.
package acc_add4_pkg;

  localparam int ACC_W_DEF = 12;
  localparam int CNT_W_DEF = 8;
  localparam int OPW       = 4;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/acc_add4_addnb.sv
// Parameterised ripple-carry adder (carry-in tied low, carry-out exposed),
// built from single-bit fulladder cells.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module addnb #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = 1'b0;
  assign co   = c[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    fulladder u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (sum[i]),
      .co(c[i+1])
    );
  end
endmodule

// File: rtl/acc_add4.sv
// Streaming accumulator for 4-bit operands with a held result handshake.
// Define ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
//
// state   | meaning
// ST_ACC  | accepting operand beats, summing into acc
// ST_HOLD | result presented, waiting for out_ready
module acc_add4
  import acc_add4_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, nsum, acc_add;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             ovf, ovf_nxt, ovf_add;
  logic             cy;
  logic             accept, load_out;

  addnb #(.W(ACC_W)) u_add (
    .a  (acc),
    .b  ({{(ACC_W-OPW){1'b0}}, in_data}),
    .sum(nsum),
    .co (cy)
  );

`ifdef ACC_SAT_EN
  // Once pinned at all-ones, any further beat carries out again, so it stays pinned.
  assign acc_add = cy ? {ACC_W{1'b1}} : nsum;
`else
  assign acc_add = nsum;
`endif

  assign ovf_add = ovf | cy;
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  assign accept    = (state == ST_ACC) && in_valid;
  assign in_ready  = rst_n && (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    load_out  = 1'b0;
    unique case (state)
      ST_ACC: begin
        if (accept) begin
          if (in_last) begin
            load_out  = 1'b1;
            state_nxt = ST_HOLD;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end else begin
            acc_nxt = acc_add;
            cnt_nxt = cnt_inc;
            ovf_nxt = ovf_add;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_ACC;
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      if (load_out) begin
        out_sum   <= acc_add;
        out_beats <= cnt_inc;
        out_ovf   <= ovf_add;
      end
    end
  end

endmodule

// File: doc/acc_add4.md
# acc_add4

Streaming accumulating adder, the additive counterpart of the 4-bit ripple subtractor in the TPU datapath. It accepts a stream of 4-bit unsigned operands over a valid/ready handshake and sums them into an ACC_W-bit accumulator. On the beat flagged `in_last` it presents the total, a beat count and an overflow flag on a held output handshake. It sits between the operand feeder and the partial-sum writeback stage.

## Interface
- `ACC_W`, 12, accumulator and result width in bits; must be ≥ 5.
- `CNT_W`, 8, width of the beat counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  4  unsigned operand.
- `in_last`  in  1  marks the final beat of a group; qualified by `in_valid`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  ACC_W  group total.
- `out_beats`  out  CNT_W  number of beats in the group.
- `out_ovf`  out  1  sticky flag: accumulation exceeded 2^ACC_W−1 at least once in the group.

## Operation
- FSM has two states:
  - ACC: `in_ready`=1 and `out_valid`=0.
  - HOLD: `in_ready`=0 and `out_valid`=1.
- Reset (`rst_n`=0 at a clock edge): state=ACC, accumulator=0, beat count=0, ovf=0, `out_sum`=0, `out_beats`=0, `out_ovf`=0, `out_valid`=0. `in_ready` is forced to 0 while `rst_n`=0.
- Accepted beat (ACC && `in_valid`):
  - `nsum` = acc + zero-extended `in_data`.
  - `cy` = carry out of bit ACC_W−1.
  - The accumulator takes `nsum` (wraps modulo 2^ACC_W).
  - ovf |= `cy`.
  - The beat count increments, saturating at 2^CNT_W−1.
- Last beat (accepted && `in_last`):
  - `out_sum`, `out_beats` and `out_ovf` load the values including this beat.
  - The FSM moves to HOLD.
  - The accumulator, beat count and ovf clear to 0 in the same edge.
- HOLD: the outputs stay stable until `out_ready`=1. On that edge the FSM returns to ACC and `out_valid` drops.
- A single-beat group (first beat has `in_last`=1) is legal.
- `in_data` and `in_last` are ignored when `in_valid`=0 or `in_ready`=0.
- Reset mid-group or in HOLD discards all partial state and any unaccepted result.

## Timing
- Accepting a last beat at edge N gives `out_valid`=1 after edge N.
- The earliest next beat is accepted at the edge after `out_ready` is sampled high in HOLD. Peak throughput is therefore one group per (beats + 1) cycles when `out_ready` is tied high.
- The adder path is single-cycle combinational into the accumulator register; there is no internal pipelining.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `ACC_SAT_EN` defined: when `cy`=1, the accumulator takes all-ones (2^ACC_W−1) instead of the wrapped value, and it stays saturated for the rest of the group. `out_ovf` behaves identically in both builds.
- `ACC_SAT_EN` undefined: wrap-around arithmetic as described in Operation.

## Structure
- The shared TPU package holds:
  - the state enum (`ST_ACC`, `ST_HOLD`);
  - the default `ACC_W`/`CNT_W` constants;
  - the operand width constant (4).
- Sub-module `addnb`: a parameterised ripple-carry adder built from the existing `fulladder` cells, with a carry-in tied to 0 and an exposed carry-out. It is the structural inverse of `sub4b`, and the accumulator instantiates it at width ACC_W.

## Test plan
- Reset, then beats 3, 5, 7 (last on 7) with `out_ready`=1 → `out_valid` the cycle after the last beat, `out_sum`=15, `out_beats`=3, `out_ovf`=0.
- Single beat `in_data`=9 with `in_last`=1 → `out_sum`=9, `out_beats`=1. Hold `out_ready`=0 for 4 cycles → outputs stable and `in_ready`=0 throughout.
- ACC_W=5, beats 15, 15, 4 (last) → wrap build: `out_sum`=2, `out_ovf`=1. With `ACC_SAT_EN`: `out_sum`=31, `out_ovf`=1.
- Two back-to-back groups {1, 2} and {4}: second group's first beat offered during HOLD → not accepted until after `out_ready`. Results are 3 then 4, and the second group's `out_beats`=1, showing the accumulator cleared.
- `rst_n` pulsed low after beats 6, 6 of a group, then beat 2 (last) → `out_sum`=2, `out_beats`=1, `out_ovf`=0.
- CNT_W=2 with 5 beats of 1 → `out_sum`=5, `out_beats`=3 (saturated).
